// File: rtl/pc_update_ctrl_pkg.sv
// Shared definitions for the PC update sequencer: PC-source mux select
// codes, instruction classes, exception causes, vector byte addresses and
// the sequencer state encoding, plus small decode helpers.
package pc_update_ctrl_pkg;

    // PC-source mux select codes; nothing outside this set is ever driven.
    localparam logic [2:0] SRC_BRANCH = 3'b000;
    localparam logic [2:0] SRC_PC4    = 3'b001;
    localparam logic [2:0] SRC_JUMP   = 3'b010;
    localparam logic [2:0] SRC_VECTOR = 3'b100;
    localparam logic [2:0] SRC_REG    = 3'b101;

    // Fixed locations of the exception handler bytes.
    localparam logic [7:0] VEC_OPCODE = 8'd253;
    localparam logic [7:0] VEC_OVF    = 8'd254;
    localparam logic [7:0] VEC_DIV0   = 8'd255;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_BLE  = 3'd3,
        OP_BGT  = 3'd4,
        OP_JUMP = 3'd5,
        OP_JR   = 3'd6,
        OP_RTE  = 3'd7
    } op_class_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_OPCODE = 2'd1,
        CAUSE_OVF    = 2'd2,
        CAUSE_DIV0   = 2'd3
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INC      = 3'd1,
        ST_WAIT_RES = 3'd2,
        ST_UPDATE   = 3'd3,
        ST_EXC_EPC  = 3'd4,
        ST_EXC_WAIT = 3'd5,
        ST_EXC_LOAD = 3'd6,
        ST_DONE     = 3'd7
    } state_e;

    // Handler byte address for a latched cause (0 when there is none).
    function automatic logic [7:0] vec_addr_of(input cause_e c);
        logic [7:0] a;
        case (c)
            CAUSE_OPCODE: a = VEC_OPCODE;
            CAUSE_OVF:    a = VEC_OVF;
            CAUSE_DIV0:   a = VEC_DIV0;
            default:      a = 8'd0;
        endcase
        return a;
    endfunction

    // Mux select used when a taken branch/jump redirects the PC.
    function automatic logic [2:0] redirect_src_of(input op_class_e op);
        logic [2:0] s;
        case (op)
            OP_JUMP:        s = SRC_JUMP;
            OP_JR, OP_RTE:  s = SRC_REG;
            default:        s = SRC_BRANCH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pc_update_ctrl_branch_eval.sv
// pc_branch_eval: combinational taken decision for one instruction.
//   op_class : instruction class (SEQ/BEQ/BNE/BLE/BGT/JUMP/JR/RTE)
//   alu_zero : ALU zero flag
//   alu_gt   : ALU greater-than flag
//   taken    : 1 when the PC must be redirected
module pc_branch_eval
    import pc_update_ctrl_pkg::*;
(
    input  logic [2:0] op_class,
    input  logic       alu_zero,
    input  logic       alu_gt,
    output logic       taken
);

    // Per-class condition; unconditional transfers are always taken.
    always_comb begin
        taken = 1'b0;
        case (op_class_e'(op_class))
            OP_SEQ:                  taken = 1'b0;
            OP_BEQ:                  taken = alu_zero;
            OP_BNE:                  taken = ~alu_zero;
            OP_BLE:                  taken = alu_zero | ~alu_gt;
            OP_BGT:                  taken = alu_gt;
            OP_JUMP, OP_JR, OP_RTE:  taken = 1'b1;
            default:                 taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl: multicycle sequencer driving the PC-source mux select,
// PC write enable and EPC write enable for one instruction at a time.
// Flows: PC+4 increment, taken redirect, and exception entry (write EPC,
// read the handler byte from 253/254/255, load PC from it).
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : begin PC handling (honoured only when idle)
//   resolve               : op_class / ALU flags / exception flags valid
//   op_class, alu_zero, alu_gt, exc_opcode, exc_ovf, exc_div0 : resolve data
//   pc_source, pc_write   : PC mux select and PC write enable
//   epc_write             : EPC write enable
//   mem_rd, vec_addr      : handler byte read request and address
//   cause                 : latched exception cause
//   busy, done            : not idle / one-cycle completion pulse
// All outputs are registers loaded with the decode of the next state, so
// they behave as Moore outputs of the current state.
module pc_update_ctrl
    import pc_update_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       resolve,
    input  logic [2:0] op_class,
    input  logic       alu_zero,
    input  logic       alu_gt,
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic [2:0] pc_source,
    output logic       pc_write,
    output logic       epc_write,
    output logic       mem_rd,
    output logic [7:0] vec_addr,
    output logic [1:0] cause,
    output logic       busy,
    output logic       done
);

    state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    op_class_e        op_r, op_nxt_s;
    cause_e           cause_r, cause_nxt_s;
    cause_e           exc_cause_s;
    logic             taken_s;

    logic [2:0]       pc_source_nxt_s;
    logic             pc_write_nxt_s;
    logic             epc_write_nxt_s;
    logic             mem_rd_nxt_s;
    logic [7:0]       vec_addr_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;

    pc_branch_eval u_branch_eval (
        .op_class (op_class),
        .alu_zero (alu_zero),
        .alu_gt   (alu_gt),
        .taken    (taken_s)
    );

    // Exception priority: invalid opcode, then overflow, then divide by zero.
    always_comb begin
        exc_cause_s = CAUSE_NONE;
        if (exc_opcode) begin
            exc_cause_s = CAUSE_OPCODE;
        end else if (exc_ovf) begin
            exc_cause_s = CAUSE_OVF;
        end else if (exc_div0) begin
            exc_cause_s = CAUSE_DIV0;
        end else begin
            exc_cause_s = CAUSE_NONE;
        end
    end

    // Next state, wait counter and resolve-time captures.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        op_nxt_s    = op_r;
        cause_nxt_s = cause_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_INC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_INC: state_nxt_s = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (resolve) begin
                    op_nxt_s    = op_class_e'(op_class);
                    cause_nxt_s = exc_cause_s;
                    if (exc_cause_s != CAUSE_NONE) begin
                        state_nxt_s = ST_EXC_EPC;
                    end else if (taken_s) begin
                        state_nxt_s = ST_UPDATE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_RES;
                end
            end
            ST_UPDATE: state_nxt_s = ST_DONE;
            ST_EXC_EPC: begin
                cnt_nxt_s   = CNT_W'(MEM_LAT);
                state_nxt_s = ST_EXC_WAIT;
            end
            ST_EXC_WAIT: begin
                // The counter enters holding MEM_LAT, so the last wait
                // cycle is the one that sees 1.
                cnt_nxt_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = ST_EXC_LOAD;
                end else begin
                    state_nxt_s = ST_EXC_WAIT;
                end
            end
            ST_EXC_LOAD: state_nxt_s = ST_DONE;
            ST_DONE:     state_nxt_s = ST_IDLE;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode of the state being entered.
    always_comb begin
        pc_source_nxt_s = SRC_BRANCH;
        pc_write_nxt_s  = 1'b0;
        epc_write_nxt_s = 1'b0;
        mem_rd_nxt_s    = 1'b0;
        vec_addr_nxt_s  = 8'd0;
        done_nxt_s      = 1'b0;
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        case (state_nxt_s)
            ST_INC: begin
                pc_source_nxt_s = SRC_PC4;
                pc_write_nxt_s  = 1'b1;
            end
            ST_UPDATE: begin
                pc_source_nxt_s = redirect_src_of(op_nxt_s);
                pc_write_nxt_s  = 1'b1;
            end
            ST_EXC_EPC: begin
                epc_write_nxt_s = 1'b1;
                mem_rd_nxt_s    = 1'b1;
                vec_addr_nxt_s  = vec_addr_of(cause_nxt_s);
            end
            ST_EXC_WAIT: begin
                mem_rd_nxt_s   = 1'b1;
                vec_addr_nxt_s = vec_addr_of(cause_nxt_s);
            end
            ST_EXC_LOAD: begin
                pc_source_nxt_s = SRC_VECTOR;
                pc_write_nxt_s  = 1'b1;
            end
            ST_DONE: done_nxt_s = 1'b1;
            default: done_nxt_s = 1'b0;
        endcase
    end

    // State, captures and registered outputs; reset aborts any flow at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            op_r      <= OP_SEQ;
            cause_r   <= CAUSE_NONE;
            pc_source <= 3'b000;
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            mem_rd    <= 1'b0;
            vec_addr  <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            op_r      <= op_nxt_s;
            cause_r   <= cause_nxt_s;
            pc_source <= pc_source_nxt_s;
            pc_write  <= pc_write_nxt_s;
            epc_write <= epc_write_nxt_s;
            mem_rd    <= mem_rd_nxt_s;
            vec_addr  <= vec_addr_nxt_s;
            busy      <= busy_nxt_s;
            done      <= done_nxt_s;
        end
    end

    assign cause = cause_r;

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Scoreboard bench for pc_update_ctrl. The driver computes, from the
// instruction's class, flags and resolve time, the cycle-stamped list of
// observable events (PC write, EPC write, vector read, done) and queues it;
// the monitor pops one entry whenever the DUT shows any such event.
module tb_pc_update_ctrl;

    localparam int L = 3;

    typedef struct {
        int         cyc;
        bit         pcw;
        bit         epcw;
        bit         mrd;
        bit         dn;
        logic [2:0] src;
        logic [7:0] vec;
        logic [1:0] cs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       resolve = 1'b0;
    logic [2:0] op_class = 3'd0;
    logic       alu_zero = 1'b0;
    logic       alu_gt = 1'b0;
    logic       exc_opcode = 1'b0;
    logic       exc_ovf = 1'b0;
    logic       exc_div0 = 1'b0;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       epc_write;
    logic       mem_rd;
    logic [7:0] vec_addr;
    logic [1:0] cause;
    logic       busy;
    logic       done;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   win_lo = 1;
    int   win_hi = 0;

    pc_update_ctrl #(.MEM_LAT(L), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .resolve    (resolve),
        .op_class   (op_class),
        .alu_zero   (alu_zero),
        .alu_gt     (alu_gt),
        .exc_opcode (exc_opcode),
        .exc_ovf    (exc_ovf),
        .exc_div0   (exc_div0),
        .pc_source  (pc_source),
        .pc_write   (pc_write),
        .epc_write  (epc_write),
        .mem_rd     (mem_rd),
        .vec_addr   (vec_addr),
        .cause      (cause),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle stamp, advanced at each active edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit ref_taken(input int op, input bit z, input bit g);
        case (op)
            0:       return 1'b0;
            1:       return z;
            2:       return !z;
            3:       return !(g && !z);
            4:       return g;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void push_ev(input int c, input bit pcw, input bit epcw, input bit mrd,
                                    input bit dn, input logic [2:0] src, input logic [7:0] vec,
                                    input logic [1:0] cs);
        exp_t e;
        e.cyc = c; e.pcw = pcw; e.epcw = epcw; e.mrd = mrd;
        e.dn = dn; e.src = src; e.vec = vec; e.cs = cs;
        q.push_back(e);
    endfunction

    // Monitor: exclusivity, busy window and event scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (pc_write && epc_write) begin
                n_fail++;
                $display("FAIL write_exclusive: cyc=%0d pc_write=%b epc_write=%b, required not both", cyc, pc_write, epc_write);
            end
            n_checks++;
            if (busy !== (cyc >= win_lo && cyc <= win_hi)) begin
                n_fail++;
                $display("FAIL busy: cyc=%0d got %b, required %b", cyc, busy, (cyc >= win_lo && cyc <= win_hi));
            end
            if (pc_write || epc_write || mem_rd || done) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_event: cyc=%0d pcw=%b epcw=%b mrd=%b done=%b src=%b, required no event",
                             cyc, pc_write, epc_write, mem_rd, done, pc_source);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (!(e.cyc == cyc && pc_write == e.pcw && epc_write == e.epcw && mem_rd == e.mrd &&
                          done == e.dn && (!e.pcw || pc_source == e.src) && (!e.mrd || vec_addr == e.vec) &&
                          (!e.dn || cause == e.cs))) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d pcw=%b epcw=%b mrd=%b done=%b src=%b vec=%0d cause=%0d; required cyc=%0d pcw=%b epcw=%b mrd=%b done=%b src=%b vec=%0d cause=%0d",
                                 cyc, pc_write, epc_write, mem_rd, done, pc_source, vec_addr, cause,
                                 e.cyc, e.pcw, e.epcw, e.mrd, e.dn, e.src, e.vec, e.cs);
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({pc_source, pc_write, epc_write, mem_rd, vec_addr, cause, busy, done} !== 19'd0) begin
            n_fail++;
            $display("FAIL %s: src=%b pcw=%b epcw=%b mrd=%b vec=%0d cause=%0d busy=%b done=%b, required all 0",
                     tag, pc_source, pc_write, epc_write, mem_rd, vec_addr, cause, busy, done);
        end
    endtask

    task automatic check_drained(input string tag);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events never seen (next at cyc %0d), required 0", tag, q.size(), q[0].cyc);
            q.delete();
        end
    endtask

    // One instruction: start, optional resolve delay, optional noise on
    // ignored inputs (stray resolve/flags/start while busy).
    task automatic run_txn(input int op, input bit z, input bit g, input bit eo, input bit eov,
                           input bit ed, input int rd, input bit noise);
        int s, r, dc, cs;
        bit tk;
        @(posedge clk); #2;
        s  = cyc;
        r  = s + 2 + rd;
        cs = eo ? 1 : (eov ? 2 : (ed ? 3 : 0));
        tk = ref_taken(op, z, g);
        push_ev(s + 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 8'd0, 2'd0);
        if (cs != 0) begin
            push_ev(r + 1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 8'(252 + cs), 2'd0);
            for (int k = 0; k < L; k++)
                push_ev(r + 2 + k, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 8'(252 + cs), 2'd0);
            push_ev(r + 2 + L, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 8'd0, 2'd0);
            dc = r + 3 + L;
        end else if (tk) begin
            push_ev(r + 1, 1'b1, 1'b0, 1'b0, 1'b0, (op == 5) ? 3'b010 : ((op >= 6) ? 3'b101 : 3'b000), 8'd0, 2'd0);
            dc = r + 2;
        end else begin
            dc = r + 1;
        end
        push_ev(dc, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 8'd0, 2'(cs));
        win_lo = s + 1;
        win_hi = dc;
        start  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #2;
            start = 1'b0; resolve = 1'b0;
            op_class = 3'd0; alu_zero = 1'b0; alu_gt = 1'b0;
            exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
            if (cyc > dc) break;
            if (cyc == r) begin
                resolve = 1'b1; op_class = 3'(op); alu_zero = z; alu_gt = g;
                exc_opcode = eo; exc_ovf = eov; exc_div0 = ed;
            end else if (noise) begin
                op_class = 3'($urandom_range(0, 7));
                alu_zero = 1'($urandom_range(0, 1)); alu_gt = 1'($urandom_range(0, 1));
                exc_opcode = 1'($urandom_range(0, 1)); exc_ovf = 1'($urandom_range(0, 1));
                exc_div0 = 1'($urandom_range(0, 1));
                if (cyc == s + 1 || cyc > r) resolve = 1'($urandom_range(0, 1));
                if (cyc > r) start = 1'($urandom_range(0, 1));
            end
        end
        repeat (2) @(posedge clk);
        #2;
        check_drained("txn_drain");
    endtask

    // Overflow exception aborted by reset while waiting for the vector byte.
    task automatic reset_midflow();
        int s;
        @(posedge clk); #2;
        s = cyc;
        push_ev(s + 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 8'd0, 2'd0);
        push_ev(s + 3, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 8'd254, 2'd0);
        win_lo = s + 1;
        win_hi = s + 3;
        start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        @(posedge clk); #2; resolve = 1'b1; exc_ovf = 1'b1;
        @(posedge clk); #2; resolve = 1'b0; exc_ovf = 1'b0;
        @(posedge clk); #2;
        check_drained("pre_reset_events");
        reset = 1'b1;
        #1;
        check_all_zero("reset_midflow");
        win_lo = 1;
        win_hi = 0;
        @(posedge clk); #2;
        check_all_zero("reset_held");
        reset = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        #3;
        check_all_zero("reset_state");
        @(posedge clk); #2;
        reset = 1'b0;
        //        op z  g  eo eov ed rd noise
        run_txn(0, 0, 0, 0, 0, 0, 0, 0);   // SEQ
        run_txn(1, 1, 0, 0, 0, 0, 0, 0);   // BEQ taken
        run_txn(1, 0, 0, 0, 0, 0, 0, 0);   // BEQ not taken
        run_txn(6, 0, 0, 0, 0, 0, 0, 0);   // JR
        run_txn(5, 0, 0, 0, 0, 0, 0, 0);   // JUMP
        run_txn(4, 0, 0, 0, 0, 0, 0, 0);   // BGT not taken
        run_txn(0, 0, 0, 0, 1, 0, 0, 0);   // overflow
        run_txn(2, 0, 1, 1, 0, 1, 1, 0);   // opcode beats div0, late resolve
        run_txn(0, 1, 1, 0, 0, 0, 0, 1);   // stray flags/resolve/start ignored
        reset_midflow();
        run_txn(3, 0, 0, 0, 0, 0, 0, 0);   // BLE taken after reset
        for (int i = 0; i < 60; i++) begin
            run_txn(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
